// File: rtl/picoblaze_pkg.sv
// Shared constants and types for the PicoBlaze port bridge: IRQ FSM
// encoding, default port map and an elaboration-time address map check.
package picoblaze_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_REQ      = 2'd1,
    IRQ_WAIT_CLR = 2'd2
  } irq_state_t;

  localparam logic [7:0] DEF_IN_BASE   = 8'h00;
  localparam logic [7:0] DEF_OUT_BASE  = 8'h04;
  localparam logic [7:0] DEF_EVT_ADDR  = 8'h10;
  localparam logic [7:0] DEF_MASK_ADDR = 8'h11;

  // True when port counts are in range and no two mapped addresses collide.
  function automatic bit addr_map_ok(input int n_in, input int n_out,
                                     input logic [7:0] in_base,
                                     input logic [7:0] out_base,
                                     input logic [7:0] evt_addr,
                                     input logic [7:0] mask_addr);
    logic [7:0] a;
    logic [7:0] b;
    bit ok;
    ok = (n_in >= 1) && (n_in <= 8) && (n_out >= 1) && (n_out <= 8) &&
         (evt_addr != mask_addr);
    for (int i = 0; i < 8; i++) begin
      if (i < n_in) begin
        a = in_base + 8'(i);
        if (a == evt_addr || a == mask_addr) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          if (j < n_out) begin
            b = out_base + 8'(j);
            if (a == b) ok = 1'b0;
          end
        end
      end
    end
    for (int j = 0; j < 8; j++) begin
      if (j < n_out) begin
        b = out_base + 8'(j);
        if (b == evt_addr || b == mask_addr) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/picoblaze_port_bridge_sync_edge.sv
// Two-flop synchroniser with rising-edge detect on the synchronised value.
module sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] prev;

  // Synchroniser chain plus one flop of edge history; history starts at 0
  // so inputs already high when reset releases report one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= '0;
      q    <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;

endmodule

// File: rtl/picoblaze_port_bridge.sv
// PicoBlaze I/O bridge: synchronised input ports, registered output ports,
// a sticky edge-event register with interrupt mask, and the IRQ handshake.
//
// state        | meaning
// IRQ_IDLE     | no unmasked event pending, interrupt low
// IRQ_REQ      | interrupt high until the processor acknowledges
// IRQ_WAIT_CLR | acknowledged, waiting for software to clear masked events
module picoblaze_port_bridge
  import picoblaze_pkg::*;
#(
  parameter int         N_IN      = 2,
  parameter int         N_OUT     = 2,
  parameter logic [7:0] IN_BASE   = DEF_IN_BASE,
  parameter logic [7:0] OUT_BASE  = DEF_OUT_BASE,
  parameter logic [7:0] EVT_ADDR  = DEF_EVT_ADDR,
  parameter logic [7:0] MASK_ADDR = DEF_MASK_ADDR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           port_id,
  input  logic [7:0]           out_port,
  input  logic                 write_strobe,
  input  logic                 k_write_strobe,
  input  logic                 read_strobe,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  input  logic [8*N_IN-1:0]    in_data,
  output logic [8*N_OUT-1:0]   out_data
);

  if (!addr_map_ok(N_IN, N_OUT, IN_BASE, OUT_BASE, EVT_ADDR, MASK_ADDR)) begin : g_bad_map
    $error("picoblaze_port_bridge: port counts out of range or address map overlaps");
  end

  logic [8*N_IN-1:0] in_sync;
  logic [8*N_IN-1:0] in_rise;
  logic [7:0]        evt;
  logic [7:0]        mask;
  logic [7:0]        rd_data;
  logic [7:0]        evt_clr;
  logic [N_OUT-1:0]  out_we;
  irq_state_t        state;
  irq_state_t        state_next;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    sync_edge #(.WIDTH(8)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d     (in_data[8*i +: 8]),
      .q     (in_sync[8*i +: 8]),
      .rise  (in_rise[8*i +: 8])
    );
  end

  // Read mux; addresses are distinct so at most one term matches.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N_IN; i++)
      if (port_id == IN_BASE + 8'(i)) rd_data = in_sync[8*i +: 8];
    for (int j = 0; j < N_OUT; j++)
      if (port_id == OUT_BASE + 8'(j)) rd_data = out_data[8*j +: 8];
    if (port_id == EVT_ADDR)  rd_data = evt;
    if (port_id == MASK_ADDR) rd_data = mask;
  end

  // Output-port write enables; OUTPUTK only sees the low nibble of port_id.
  always_comb begin
    out_we = '0;
    for (int j = 0; j < N_OUT; j++)
      out_we[j] = (write_strobe && port_id == OUT_BASE + 8'(j)) ||
                  (k_write_strobe && port_id[3:0] == 4'(OUT_BASE + 8'(j)));
  end

  // Clear only the bits the processor actually saw: in_port holds the evt
  // value captured one cycle earlier, so an edge arriving during the read
  // is kept.
  assign evt_clr = (read_strobe && port_id == EVT_ADDR) ? in_port : 8'h00;

  // Datapath registers: read data, output ports, mask and sticky events.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_port  <= 8'h00;
      out_data <= '0;
      mask     <= 8'h00;
      evt      <= 8'h00;
    end else begin
      in_port <= rd_data;
      for (int j = 0; j < N_OUT; j++)
        if (out_we[j]) out_data[8*j +: 8] <= out_port;
      if (write_strobe && port_id == MASK_ADDR) mask <= out_port;
      evt <= (evt & ~evt_clr) | in_rise[7:0];
    end
  end

  // IRQ state register; interrupt is registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IRQ_IDLE;
      interrupt <= 1'b0;
    end else begin
      state     <= state_next;
      interrupt <= (state_next == IRQ_REQ);
    end
  end

  // IRQ next-state logic; a mask change cannot pull the request back.
  always_comb begin
    state_next = state;
    case (state)
      IRQ_IDLE:     if ((evt & mask) != 8'h00) state_next = IRQ_REQ;
      IRQ_REQ:      if (interrupt_ack)         state_next = IRQ_WAIT_CLR;
      IRQ_WAIT_CLR: if ((evt & mask) == 8'h00) state_next = IRQ_IDLE;
      default:                                 state_next = IRQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_picoblaze_port_bridge.sv
// Bench for picoblaze_port_bridge: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_picoblaze_port_bridge;

  localparam int         N_IN      = 2;
  localparam int         N_OUT     = 2;
  localparam logic [7:0] IN_BASE   = 8'h00;
  localparam logic [7:0] OUT_BASE  = 8'h04;
  localparam logic [7:0] EVT_ADDR  = 8'h10;
  localparam logic [7:0] MASK_ADDR = 8'h11;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic [7:0]          port_id = 8'h00;
  logic [7:0]          out_port = 8'h00;
  logic                write_strobe = 1'b0;
  logic                k_write_strobe = 1'b0;
  logic                read_strobe = 1'b0;
  logic [7:0]          in_port;
  logic                interrupt;
  logic                interrupt_ack = 1'b0;
  logic [8*N_IN-1:0]   in_data = '0;
  logic [8*N_OUT-1:0]  out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  picoblaze_port_bridge #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE),
    .EVT_ADDR(EVT_ADDR), .MASK_ADDR(MASK_ADDR)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .in_port        (in_port),
    .interrupt      (interrupt),
    .interrupt_ack  (interrupt_ack),
    .in_data        (in_data),
    .out_data       (out_data)
  );

  // Behavioural model: inputs seen through a two-sample delay line, the
  // processor-visible registers, and the interrupt handshake as two flags.
  logic [7:0] m_late[N_IN];
  logic [7:0] m_seen[N_IN];
  logic [7:0] m_seen_before0;
  logic [7:0] m_evt, m_mask, m_in_port;
  logic [7:0] m_out[N_OUT];
  bit         m_asking, m_waiting, m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) begin
      m_late[i] = 8'h00;
      m_seen[i] = 8'h00;
    end
    for (int j = 0; j < N_OUT; j++) m_out[j] = 8'h00;
    m_seen_before0 = 8'h00;
    m_evt = 8'h00; m_mask = 8'h00; m_in_port = 8'h00;
    m_asking = 0; m_waiting = 0; m_irq = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int k;
    k = int'(a) - int'(IN_BASE);
    if (k >= 0 && k < N_IN) return m_seen[k];
    k = int'(a) - int'(OUT_BASE);
    if (k >= 0 && k < N_OUT) return m_out[k];
    if (a == EVT_ADDR) return m_evt;
    if (a == MASK_ADDR) return m_mask;
    return 8'h00;
  endfunction

  task automatic model_step();
    logic [7:0] rise, rd, seen_clear, pending;
    rise       = m_seen[0] & ~m_seen_before0;
    rd         = m_read(port_id);
    seen_clear = (read_strobe && port_id == EVT_ADDR) ? m_in_port : 8'h00;
    pending    = m_evt & m_mask;
    if (m_asking) begin
      if (interrupt_ack) begin
        m_asking = 0;
        m_waiting = 1;
      end
    end else if (m_waiting) begin
      if (pending == 8'h00) m_waiting = 0;
    end else if (pending != 8'h00) begin
      m_asking = 1;
    end
    m_irq = m_asking;
    for (int j = 0; j < N_OUT; j++) begin
      if ((write_strobe && port_id == 8'(int'(OUT_BASE) + j)) ||
          (k_write_strobe && port_id[3:0] == 4'(int'(OUT_BASE) + j)))
        m_out[j] = out_port;
    end
    if (write_strobe && port_id == MASK_ADDR) m_mask = out_port;
    m_evt = (m_evt & ~seen_clear) | rise;
    m_in_port = rd;
    m_seen_before0 = m_seen[0];
    for (int i = 0; i < N_IN; i++) begin
      m_seen[i] = m_late[i];
      m_late[i] = in_data[8*i +: 8];
    end
  endtask

  always @(posedge clk_i) if (!rst_i) model_step();

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    logic [8*N_OUT-1:0] exp_out;
    if (!rst_i) begin
      for (int j = 0; j < N_OUT; j++) exp_out[8*j +: 8] = m_out[j];
      chk("model_in_port", 32'(in_port), 32'(m_in_port));
      chk("model_out_data", 32'(out_data), 32'(exp_out));
      chk("model_interrupt", 32'(interrupt), 32'(m_irq));
    end
  end

  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic strobes_off();
    write_strobe = 0; k_write_strobe = 0; read_strobe = 0; interrupt_ack = 0;
  endtask

  task automatic wait_irq(input string name, input int max);
    int n;
    n = 0;
    while (interrupt !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
    chk(name, 32'(interrupt), 32'd1);
  endtask

  task automatic write_port(input logic [7:0] a, input logic [7:0] d, input bit k);
    port_id = a; out_port = d;
    if (k) k_write_strobe = 1; else write_strobe = 1;
    cyc();
    strobes_off();
  endtask

  logic [7:0] addrs[12] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06,
                            8'h10, 8'h11, 8'h14, 8'h15, 8'h24, 8'h1F};

  initial begin
    #1;
    rst_i = 1;
    model_reset();
    cycles(2);
    chk("rst_in_port", 32'(in_port), 32'h00);
    chk("rst_out_data", 32'(out_data), 32'h0000);
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    rst_i = 0;

    // Synchronised read of input port 0.
    in_data = 16'h0005; port_id = 8'h00;
    cycles(2);
    chk("rd_in0_early", 32'(in_port), 32'h00);
    cyc();
    chk("rd_in0", 32'(in_port), 32'h05);

    // Normal and OUTPUTK writes, ignored writes.
    write_port(8'h05, 8'hA5, 0);
    chk("wr_port1", 32'(out_data[15:8]), 32'hA5);
    chk("wr_port0_kept", 32'(out_data[7:0]), 32'h00);
    write_port(8'h14, 8'h3C, 1);
    chk("kwr_port0", 32'(out_data[7:0]), 32'h3C);
    write_port(8'h01, 8'h77, 0);
    write_port(8'h11, 8'hFF, 1);
    chk("wr_input_ignored", 32'(out_data), 32'hA53C);
    port_id = MASK_ADDR;
    cyc();
    chk("k_no_mask", 32'(in_port), 32'h00);

    // Event, interrupt, acknowledge and clear.
    in_data = 16'h0000; port_id = EVT_ADDR;
    cycles(4);
    chk("evt_first", 32'(in_port), 32'h05);
    read_strobe = 1; cyc(); read_strobe = 0; cyc();
    chk("evt_cleared", 32'(in_port), 32'h00);
    write_port(MASK_ADDR, 8'h01, 0);
    port_id = MASK_ADDR; cyc();
    chk("mask_rd", 32'(in_port), 32'h01);
    in_data = 16'h0001; port_id = EVT_ADDR;
    wait_irq("irq_set", 10);
    cyc();
    chk("evt_bit0", 32'(in_port), 32'h01);
    interrupt_ack = 1; cyc(); interrupt_ack = 0;
    chk("irq_after_ack", 32'(interrupt), 32'd0);
    read_strobe = 1; cyc(); read_strobe = 0; cyc();
    chk("evt_after_read", 32'(in_port), 32'h00);
    cycles(3);
    chk("irq_idle", 32'(interrupt), 32'd0);

    // Edge arriving in the same cycle as the clearing read.
    write_port(MASK_ADDR, 8'h00, 0);
    in_data = 16'h0003; port_id = EVT_ADDR;
    cycles(4);
    chk("evt_bit1", 32'(in_port), 32'h02);
    in_data = 16'h0001;
    cycles(4);
    in_data = 16'h0003;
    cycles(2);
    read_strobe = 1; cyc(); read_strobe = 0;
    chk("evt_read_value", 32'(in_port), 32'h02);
    cyc();
    chk("evt_same_cycle", 32'(in_port), 32'h02);

    // Mask cleared while requesting does not withdraw the interrupt.
    write_port(MASK_ADDR, 8'h02, 0);
    wait_irq("irq_bit1", 10);
    write_port(MASK_ADDR, 8'h00, 0);
    cycles(2);
    chk("irq_held_mask0", 32'(interrupt), 32'd1);

    // Asynchronous reset while interrupt is high.
    #2;
    rst_i = 1;
    #1;
    chk("async_rst_irq", 32'(interrupt), 32'd0);
    chk("async_rst_out", 32'(out_data), 32'h0000);
    model_reset();
    cycles(2);
    rst_i = 0;
    port_id = EVT_ADDR;
    cycles(5);
    chk("post_rst_edges", 32'(in_port), 32'h03);
    chk("post_rst_mask0_noirq", 32'(interrupt), 32'd0);

    // Randomized traffic in PicoBlaze-like two-cycle bus transactions.
    for (int it = 0; it < 1500; it++) begin
      int r;
      port_id = ($urandom_range(7) == 0) ? 8'($urandom) : addrs[$urandom_range(11)];
      out_port = 8'($urandom);
      strobes_off();
      interrupt_ack = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0) in_data[7:0] = in_data[7:0] ^ 8'($urandom);
      if ($urandom_range(7) == 0) in_data[15:8] = 8'($urandom);
      cyc();
      r = $urandom_range(9);
      write_strobe   = (r <= 2);
      k_write_strobe = (r == 3);
      read_strobe    = (r >= 4 && r <= 6);
      interrupt_ack  = ($urandom_range(9) == 0);
      cyc();
      strobes_off();
      if (it == 700) begin
        #3;
        rst_i = 1;
        model_reset();
        cycles(2);
        rst_i = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
